// File: rtl/fmap_serializer_pkg.sv
// Shared constants and state encoding for the feature-map serializer and the activation layer.
package fmap_serializer_pkg;

    localparam int unsigned DATA_LEN = 18;
    localparam int unsigned CH       = 32;
    localparam int unsigned PIX      = 12;
    localparam int unsigned WORDS    = CH * PIX;
    localparam int unsigned IDX_W    = $clog2(WORDS);
    localparam int unsigned CH_W     = $clog2(CH);
    localparam int unsigned PIX_W    = $clog2(PIX);

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

endpackage

// File: rtl/fmap_serializer_rise_detect.sv
// Rising-edge detector on a level input; the previous level is held in valid_q.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= level;
        end
    end

    // valid_q resets low, so a level already high at reset release is an edge.
    assign pulse = level & ~valid_q;

endmodule

// File: rtl/fmap_serializer.sv
// Captures one CH x PIX slice of the layer result bus and streams it out one word per handshake.
module fmap_serializer
    import fmap_serializer_pkg::*;
#(
    parameter int unsigned DATA_LEN = fmap_serializer_pkg::DATA_LEN,
    parameter int unsigned CH       = fmap_serializer_pkg::CH,
    parameter int unsigned PIX      = fmap_serializer_pkg::PIX
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic [CH*PIX*DATA_LEN-1:0] d,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_LEN-1:0]       out_data,
    output logic [$clog2(CH)-1:0]     out_ch,
    output logic [$clog2(PIX)-1:0]    out_pix,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int unsigned NWORDS = CH * PIX;
    localparam int unsigned IDXW   = $clog2(NWORDS);
    localparam int unsigned CHW    = $clog2(CH);
    localparam int unsigned PIXW   = $clog2(PIX);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
    localparam logic [PIXW-1:0] LAST_PIX = PIXW'(PIX - 1);

    logic                edge_s;
    logic                capture;
    state_e              state_q;
    logic [IDXW-1:0]     idx_q;
    logic [CHW-1:0]      ch_q;
    logic [PIXW-1:0]     pix_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                busy_q;
    logic                done_q;
    logic                overrun_q;
    logic [DATA_LEN-1:0] frame_q [NWORDS];

    rise_detect u_rise (
        .clk   (clk),
        .rst   (rst),
        .level (valid_in),
        .pulse (edge_s)
    );

    assign capture = edge_s && (state_q == StIdle);

    // Buffer needs no reset: it is only read while a captured frame is being sent.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < int'(NWORDS); k++) begin
                frame_q[k] <= d[k*DATA_LEN +: DATA_LEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            ch_q        <= '0;
            pix_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (edge_s) begin
                        state_q     <= StSend;
                        idx_q       <= '0;
                        ch_q        <= '0;
                        pix_q       <= '0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        out_last_q  <= (NWORDS == 1);
                    end
                end
                StSend: begin
                    if (edge_s) begin
                        overrun_q <= 1'b1;
                    end
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q     <= StIdle;
                            idx_q       <= '0;
                            ch_q        <= '0;
                            pix_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            out_last_q <= (idx_q == LAST_IDX - 1'b1);
                            if (pix_q == LAST_PIX) begin
                                pix_q <= '0;
                                ch_q  <= ch_q + 1'b1;
                            end else begin
                                pix_q <= pix_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? frame_q[idx_q] : '0;
    assign out_ch    = ch_q;
    assign out_pix   = pix_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fmap_serializer.sv
// Directed bench for fmap_serializer: reset, full frame, backpressure, overrun, mid-frame reset.
module tb_fmap_serializer;

    localparam int DL  = 18;
    localparam int CH  = 32;
    localparam int PIX = 12;
    localparam int W   = CH * PIX;

    logic              clk;
    logic              rst;
    logic              valid_in;
    logic [W*DL-1:0]   d;
    logic              out_valid;
    logic              out_ready;
    logic [DL-1:0]     out_data;
    logic [4:0]        out_ch;
    logic [3:0]        out_pix;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              overrun;

    int total = 0;
    int bad   = 0;

    fmap_serializer #(
        .DATA_LEN (DL),
        .CH       (CH),
        .PIX      (PIX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_pix   (out_pix),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_seq(input int base);
        for (int k = 0; k < W; k++) d[k*DL +: DL] = DL'(base + k);
    endtask

    task automatic check_word(input string tag, input int k, input int exp_data);
        check($sformatf("%s_valid_%0d", tag, k), 32'(out_valid), 32'd1);
        check($sformatf("%s_data_%0d", tag, k), 32'(out_data), 32'(exp_data));
        check($sformatf("%s_ch_%0d", tag, k), 32'(out_ch), 32'(k / PIX));
        check($sformatf("%s_pix_%0d", tag, k), 32'(out_pix), 32'(k % PIX));
        check($sformatf("%s_last_%0d", tag, k), 32'(out_last), 32'(k == W - 1));
    endtask

    logic [3:0] pat;
    int e;
    int hs;
    int cyc;

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b1;
        out_ready = 1'b1;
        pat       = 4'b1001;
        d         = '0;
        for (int k = 0; k < 12; k++) d[k*DL +: DL] = 18'h00400;

        // Reset held 3 cycles with valid_in high
        tick(); tick(); tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_ch", 32'(out_ch), 0);
        check("rst_pix", 32'(out_pix), 0);
        rst = 1'b0;

        // First edge after release captures; word k shown in cycle N+1+k
        tick();
        check("f1_busy", 32'(busy), 1);
        for (int k = 0; k < W; k++) begin
            check_word("f1", k, (k < 12) ? 32'h400 : 0);
            check($sformatf("f1_done_%0d", k), 32'(done), 0);
            tick();
        end
        check("f1_done", 32'(done), 1);
        check("f1_busy_end", 32'(busy), 0);
        check("f1_valid_end", 32'(out_valid), 0);
        check("f1_overrun", 32'(overrun), 0);
        tick(); tick();
        check("f1_no_recapture", 32'(out_valid), 0);
        check("f1_done_pulse", 32'(done), 0);

        // Backpressure: ready 1,0,0,1 repeating, word k = k
        valid_in = 1'b0;
        tick();
        fill_seq(0);
        valid_in = 1'b1;
        tick();
        e = 0; hs = 0; cyc = 0;
        while (e < W && cyc < 2000) begin
            out_ready = pat[cyc % 4];
            check_word("bp", e, e);
            tick();
            if (out_ready) begin
                e++;
                hs++;
            end
            cyc++;
        end
        check("bp_handshakes", 32'(hs), 32'(W));
        check("bp_done", 32'(done), 1);
        check("bp_valid_end", 32'(out_valid), 0);

        // Overrun: valid_in low at word 40, high again at word 50 with new d
        out_ready = 1'b1;
        valid_in  = 1'b0;
        tick();
        fill_seq(256);
        valid_in = 1'b1;
        tick();
        for (int k = 0; k < W; k++) begin
            if (k == 40) valid_in = 1'b0;
            if (k == 50) begin
                valid_in = 1'b1;
                d = '1;
            end
            check_word("ov", k, 256 + k);
            tick();
        end
        check("ov_done", 32'(done), 1);
        check("ov_flag", 32'(overrun), 1);
        tick(); tick();
        check("ov_sticky", 32'(overrun), 1);
        check("ov_no_capture", 32'(out_valid), 0);

        // Mid-frame reset at word 100
        valid_in = 1'b0;
        tick();
        fill_seq(512);
        valid_in = 1'b1;
        tick();
        for (int k = 0; k < 100; k++) tick();
        check_word("mr", 100, 612);
        rst      = 1'b1;
        valid_in = 1'b0;
        tick();
        rst = 1'b0;
        check("mr_valid", 32'(out_valid), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_ch", 32'(out_ch), 0);
        check("mr_pix", 32'(out_pix), 0);
        check("mr_overrun_clr", 32'(overrun), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("mr_no_done_%0d", k), 32'(done), 0);
            check($sformatf("mr_idle_%0d", k), 32'(out_valid), 0);
        end
        fill_seq(768);
        valid_in = 1'b1;
        tick();
        for (int k = 0; k < W; k++) begin
            check_word("rs", k, 768 + k);
            tick();
        end
        check("rs_done", 32'(done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
